spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- Single-channel SPI master. It sequences one DATA_WIDTH-bit full-duplex transfer per START request.
- Generates SCK, SS and MOSI, and samples MISO, for any of the four CPK/CPH modes.
- Drives the spi_receiver slave chain from the system clock domain.
- Offers a START/BUSY/DONE handshake to the host logic.

Parameters:
- CLK_DIV, 2, CLK cycles per SCK half-period; legal range 1 or more.
- DATA_WIDTH, 8, bits per transfer, shifted MSB first.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RESET  input  1  synchronous, active-low reset.
- START  input  1  transfer request; sampled only when BUSY=0.
- CPK  input  1  clock polarity (SCK idle level); latched at START.
- CPH  input  1  clock phase; latched at START.
- TX_DATA  input  DATA_WIDTH  byte to send; latched at START.
- MISO  input  1  serial data from the slave chain.
- SCK  output  1  SPI clock.
- SS  output  1  slave select, active low.
- MOSI  output  1  serial data to the slaves.
- BUSY  output  1  transfer in progress.
- DONE  output  1  one-cycle completion pulse.
- RX_DATA  output  DATA_WIDTH  received word; valid from DONE onward.

Behaviour:
- Reset values (RESET=0 at a rising edge): SCK=0, SS=1, MOSI=0, BUSY=0, DONE=0, RX_DATA=0; state=IDLE; divider and edge counter cleared.
- Reset applies in any state, including mid-transfer. The partial transfer is discarded and RX_DATA is cleared.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - SCK is registered from the CPK input each cycle.
  - START=1 at edge t0 does the following at t0: latch CPK, CPH and TX_DATA into the shift register; SS=0; BUSY=1; go to SETUP.
  - CPH=0: MOSI=TX_DATA[MSB] at t0.
- SETUP: wait CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - SCK toggles every CLK_DIV cycles. Edge k (k=1..2*DATA_WIDTH) occurs at t0 + k*CLK_DIV.
  - Odd k is the leading edge; even k is the trailing edge.
  - CPH=0: sample MISO into the shift register LSB on odd edges. On even edges k<2*DATA_WIDTH, drive the next bit onto MOSI.
  - CPH=1: drive the next bit onto MOSI on odd edges, with bit MSB at edge 1. Sample MISO on even edges.
  - After edge 2*DATA_WIDTH, SCK equals the latched CPK. Go to HOLD.
- HOLD: wait CLK_DIV cycles. Then, at t0 + (2*DATA_WIDTH+2)*CLK_DIV:
  - SS=1, MOSI=0, BUSY=0, DONE=1 for one cycle.
  - RX_DATA is loaded from the shift register and holds until the next DONE or reset.
  - Go to IDLE.
- Latency: DATA_WIDTH=8, CLK_DIV=2 gives DONE at t0+36.
- START while BUSY=1 is ignored, with no queueing. START in the DONE cycle is also ignored, because the state is leaving HOLD. This guarantees SS stays high for at least 1 CLK between transfers.
- CPK, CPH and TX_DATA changes while BUSY=1 have no effect on the current transfer.
- MISO is sampled directly with no synchronizer; it is same-domain by construction.
- Divider counter is ceil(log2(CLK_DIV+1)) bits wide.
- Edge counter is ceil(log2(2*DATA_WIDTH+1)) bits wide. Neither counter may wrap within a transfer.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: the MISO port is ignored and the sampled bit is the current MOSI register value, so RX_DATA equals TX_DATA after DONE in every mode. SCK and SS toggle as normal.
- Not defined: MISO is sampled as described in Behaviour.

Test Plan:
- Mode 0 (CPK=0, CPH=0), CLK_DIV=2, TX_DATA=8'hA5; slave model returns 8'h3C on MISO. Required response:
  - MOSI shows 1,0,1,0,0,1,0,1 on SCK rising edges.
  - SS low t0..t0+35; DONE=1 only at t0+36.
  - RX_DATA=8'h3C; BUSY high t0..t0+35.
- Mode 3 (CPK=1, CPH=1), CLK_DIV=1, TX_DATA=8'h81; MISO returns 8'h7E. Required response:
  - SCK idles 1; first edge is falling at t0+1.
  - MOSI changes on falling edges and is stable on rising edges.
  - DONE at t0+18; RX_DATA=8'h7E.
- START held high for 40 cycles in mode 1, TX_DATA changed mid-transfer from 8'h55 to 8'hFF. Required response:
  - Exactly one transfer sends 8'h55.
  - After DONE, a second transfer starts; SS is high for exactly 1 CLK between transfers.
- RESET driven low at t0+10 mid-transfer. Required response:
  - At the next edge: SS=1, SCK=0, BUSY=0, DONE=0, RX_DATA=0.
  - A new START after reset completes normally with the correct RX_DATA.
- With SPI_LOOPBACK_EN defined, mode 2, TX_DATA=8'hC3, MISO tied 0 -> RX_DATA=8'hC3 at DONE.
- Mode sweep of all four CPK/CPH combinations against a spi_receiver instance, TX_DATA=8'h96 -> data received by the slave equals 8'h96 in every mode.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// Single-channel SPI master: one DATA_WIDTH-bit full-duplex transfer per START, all four CPK/CPH modes.
// Define SPI_LOOPBACK_EN to feed the MOSI register back as the sampled bit instead of MISO.
module spi_master_ctrl #(
    parameter int CLK_DIV    = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  CPK,
    input  logic                  CPH,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  MISO,
    output logic                  SCK,
    output logic                  SS,
    output logic                  MOSI,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] RX_DATA
);
    localparam int DIV_W     = $clog2(CLK_DIV + 1);
    localparam int EDGE_W    = $clog2(2 * DATA_WIDTH + 1);
    localparam int LAST_EDGE = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [EDGE_W-1:0]     edge_q, edge_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  cpk_q, cpk_d;
    logic                  cph_q, cph_d;
    logic                  sck_q, sck_d;
    logic                  ss_q, ss_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  tick;
    logic                  miso_bit;
    logic [EDGE_W-1:0]     edge_next;

    assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
    assign edge_next = edge_q + 1'b1;

`ifdef SPI_LOOPBACK_EN
    assign miso_bit = mosi_q;
`else
    assign miso_bit = MISO;
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        edge_d  = edge_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        cpk_d   = cpk_q;
        cph_d   = cph_q;
        sck_d   = sck_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                sck_d  = CPK;
                div_d  = '0;
                edge_d = '0;
                if (START) begin
                    cpk_d   = CPK;
                    cph_d   = CPH;
                    shift_d = TX_DATA;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                    if (!CPH) begin
                        mosi_d = TX_DATA[DATA_WIDTH-1];
                    end
                end
            end
            SETUP, SHIFT: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    edge_d = edge_next;
                    sck_d  = ~sck_q;
                    // Odd edges sample when CPH=0, even edges sample when CPH=1; the other edge drives.
                    if (edge_next[0] != cph_q) begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], miso_bit};
                    end else if (edge_next != EDGE_W'(LAST_EDGE)) begin
                        mosi_d = shift_q[DATA_WIDTH-1];
                    end
                    state_d = (edge_next == EDGE_W'(LAST_EDGE)) ? HOLD : SHIFT;
                end
            end
            HOLD: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    if (edge_q == EDGE_W'(LAST_EDGE + 1)) begin
                        ss_d    = 1'b1;
                        mosi_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        rx_d    = shift_q;
                        state_d = IDLE;
                    end else begin
                        edge_d = edge_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            div_q   <= '0;
            edge_q  <= '0;
            shift_q <= '0;
            rx_q    <= '0;
            cpk_q   <= 1'b0;
            cph_q   <= 1'b0;
            sck_q   <= 1'b0;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            cpk_q   <= cpk_d;
            cph_q   <= cph_d;
            sck_q   <= sck_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SCK     = sck_q;
    assign SS      = ss_q;
    assign MOSI    = mosi_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign RX_DATA = rx_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1), each with a mode-aware SPI slave model.
module tb_spi_master_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start = 2'b00;
    logic       cpk = 1'b1;
    logic       cph = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [1:0] miso;
    logic [1:0] sck, ss, mosi, busy, done;
    logic [7:0] rx_data [2];
    logic [7:0] slv_word [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_master_ctrl #(.CLK_DIV(2), .DATA_WIDTH(8)) u_dut (
        .CLK(clk), .RESET(rst_n), .START(start[0]), .CPK(cpk), .CPH(cph),
        .TX_DATA(tx_data), .MISO(miso[0]), .SCK(sck[0]), .SS(ss[0]),
        .MOSI(mosi[0]), .BUSY(busy[0]), .DONE(done[0]), .RX_DATA(rx_data[0])
    );

    spi_master_ctrl #(.CLK_DIV(1), .DATA_WIDTH(8)) u_dut_fast (
        .CLK(clk), .RESET(rst_n), .START(start[1]), .CPK(cpk), .CPH(cph),
        .TX_DATA(tx_data), .MISO(miso[1]), .SCK(sck[1]), .SS(ss[1]),
        .MOSI(mosi[1]), .BUSY(busy[1]), .DONE(done[1]), .RX_DATA(rx_data[1])
    );

    // Slave: shifts slv_word out on MISO and collects MOSI, using SCK polarity/phase like a real receiver.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_slave
        logic [7:0] s_rx = 8'h00;
        logic [7:0] s_out = 8'h00;
        int         s_bits = 0;
        logic       ss_prev = 1'b1;
        logic       sck_prev = 1'b0;
        logic       miso_r = 1'b0;
        assign miso[gi] = miso_r;
        always @(posedge clk) begin
            #1;
            if (!ss[gi]) begin
                if (ss_prev) begin
                    s_rx   = 8'h00;
                    s_bits = 0;
                    s_out  = slv_word[gi];
                    if (!cph) begin
                        miso_r = s_out[7];
                        s_out  = s_out << 1;
                    end
                end else if (sck[gi] != sck_prev) begin
                    if ((sck[gi] != cpk) != cph) begin
                        s_rx   = {s_rx[6:0], mosi[gi]};
                        s_bits = s_bits + 1;
                    end else begin
                        miso_r = s_out[7];
                        s_out  = s_out << 1;
                    end
                end
            end
            ss_prev  = ss[gi];
            sck_prev = sck[gi];
        end
    end

    function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] sw);
`ifdef SPI_LOOPBACK_EN
        return tx;
`else
        return sw;
`endif
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] slave_rx(input int idx);
        return (idx == 0) ? g_slave[0].s_rx : g_slave[1].s_rx;
    endfunction

    function automatic int slave_bits(input int idx);
        return (idx == 0) ? g_slave[0].s_bits : g_slave[1].s_bits;
    endfunction

    // Returns at the falling edge right after t0 (the START edge).
    task automatic start_only(input int idx, input logic pol, input logic pha,
                              input logic [7:0] tx, input logic [7:0] sw);
        @(negedge clk);
        cpk = pol;
        cph = pha;
        tx_data = tx;
        slv_word[idx] = sw;
        @(negedge clk);
        start[idx] = 1'b1;
        @(negedge clk);
        start[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx, output int lat, output int ss_lo, output int busy_hi,
                             output int edges, output logic sck0, output logic sck1, output logic mosi_at_done);
        logic prev;
        lat = -1; ss_lo = 0; busy_hi = 0; edges = 0;
        sck0 = sck[idx]; sck1 = 1'bx; prev = sck[idx]; mosi_at_done = 1'bx;
        for (int n = 0; n < 200; n++) begin
            if (n == 1) sck1 = sck[idx];
            if (n > 0 && sck[idx] != prev) edges++;
            prev = sck[idx];
            if (done[idx]) begin
                lat = n;
                mosi_at_done = mosi[idx];
                break;
            end
            if (!ss[idx]) ss_lo++;
            if (busy[idx]) busy_hi++;
            @(negedge clk);
        end
    endtask

    task automatic xfer_check(input int idx, input logic pol, input logic pha, input logic [7:0] tx,
                              input logic [7:0] sw, input int exp_lat, input string tag,
                              output logic sck0, output logic sck1);
        int lat, ss_lo, busy_hi, edges;
        logic mosi_d;
        start_only(idx, pol, pha, tx, sw);
        wait_done(idx, lat, ss_lo, busy_hi, edges, sck0, sck1, mosi_d);
        $display("xfer %s dut%0d cpk=%0b cph=%0b tx=%02h rx=%02h slave_rx=%02h lat=%0d",
                 tag, idx, pol, pha, tx, rx_data[idx], slave_rx(idx), lat);
        check_val({tag, "_lat"}, lat, exp_lat);
        check_val({tag, "_ss_low"}, ss_lo, exp_lat);
        check_val({tag, "_busy_hi"}, busy_hi, exp_lat);
        check_val({tag, "_sck_edges"}, edges, 16);
        check_val({tag, "_rx"}, rx_data[idx], exp_rx(tx, sw));
        check_val({tag, "_slave_rx"}, slave_rx(idx), tx);
        check_val({tag, "_slave_bits"}, slave_bits(idx), 8);
        check_val({tag, "_mosi_done"}, mosi_d, 1'b0);
        check_val({tag, "_sck_idle"}, sck[idx], pol);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, done[idx], 1'b0);
        check_val({tag, "_ss_idle"}, ss[idx], 1'b1);
        check_val({tag, "_rx_hold"}, rx_data[idx], exp_rx(tx, sw));
    endtask

    initial begin
        logic s0, s1;
        int done_cnt, done_at, second_at;
        logic [7:0] first_rx, second_rx;
        logic ss_after;
        logic [7:0] sw_tab [4];

        slv_word[0] = 8'h00;
        slv_word[1] = 8'h00;

        // Reset state, with CPK=1 so the reset value of SCK is distinguishable.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_sck", sck[0], 1'b0);
        check_val("rst_ss", ss[0], 1'b1);
        check_val("rst_mosi", mosi[0], 1'b0);
        check_val("rst_busy", busy[0], 1'b0);
        check_val("rst_done", done[0], 1'b0);
        check_val("rst_rx", rx_data[0], 8'h00);
        check_val("rst_sck_fast", sck[1], 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_sck_follows_cpk", sck[0], 1'b1);

        // Mode 0, CLK_DIV=2
        xfer_check(0, 1'b0, 1'b0, 8'hA5, 8'h3C, 36, "mode0", s0, s1);
        check_val("mode0_sck_t0", s0, 1'b0);
        check_val("mode0_sck_t1", s1, 1'b0);

        // Mode 3, CLK_DIV=1: SCK idles high, first edge falls at t0+1
        xfer_check(1, 1'b1, 1'b1, 8'h81, 8'h7E, 18, "mode3", s0, s1);
        check_val("mode3_sck_t0", s0, 1'b1);
        check_val("mode3_sck_t1", s1, 1'b0);

        // START held for 40 cycles in mode 1, TX_DATA changes mid-transfer
        @(negedge clk);
        cpk = 1'b0; cph = 1'b1; tx_data = 8'h55; slv_word[0] = 8'hD2;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        done_cnt = 0; done_at = -1; second_at = -1;
        first_rx = 8'h00; second_rx = 8'h00; ss_after = 1'b1;
        for (int n = 0; n < 150; n++) begin
            if (n == 10) tx_data = 8'hFF;
            if (n == 39) start[0] = 1'b0;
            if (done_at >= 0 && n == done_at + 1) ss_after = ss[0];
            if (done[0]) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_at = n;
                    first_rx = g_slave[0].s_rx;
                end else begin
                    second_at = n;
                    second_rx = g_slave[0].s_rx;
                    break;
                end
            end
            @(negedge clk);
        end
        $display("xfer held_start first_done=%0d slave_rx=%02h second_done=%0d slave_rx=%02h rx=%02h",
                 done_at, first_rx, second_at, second_rx, rx_data[0]);
        check_val("held_first_done", done_at, 36);
        check_val("held_first_slave_rx", first_rx, 8'h55);
        check_val("held_ss_gap", ss_after, 1'b0);
        check_val("held_second_done", second_at, 73);
        check_val("held_second_slave_rx", second_rx, 8'hFF);
        check_val("held_rx", rx_data[0], exp_rx(8'hFF, 8'hD2));
        @(negedge clk);
        check_val("held_no_third", ss[0], 1'b1);

        // Reset mid-transfer at t0+10, mode 2 so a non-idle SCK reset value shows
        start_only(0, 1'b1, 1'b0, 8'h5A, 8'h99);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        $display("xfer midreset ss=%0b sck=%0b busy=%0b done=%0b rx=%02h",
                 ss[0], sck[0], busy[0], done[0], rx_data[0]);
        check_val("midrst_ss", ss[0], 1'b1);
        check_val("midrst_sck", sck[0], 1'b0);
        check_val("midrst_busy", busy[0], 1'b0);
        check_val("midrst_done", done[0], 1'b0);
        check_val("midrst_rx", rx_data[0], 8'h00);
        rst_n = 1'b1;
        xfer_check(0, 1'b0, 1'b0, 8'h3C, 8'hE7, 36, "after_rst", s0, s1);

        // Mode 2 with the slave returning all zeros (loopback returns TX_DATA)
        xfer_check(0, 1'b1, 1'b0, 8'hC3, 8'h00, 36, "mode2_zero_miso", s0, s1);

        // Mode sweep against the slave model
        sw_tab[0] = 8'h69; sw_tab[1] = 8'h0F; sw_tab[2] = 8'hF0; sw_tab[3] = 8'h5A;
        for (int m = 0; m < 4; m++) begin
            logic [1:0] mb;
            mb = m[1:0];
            xfer_check(0, mb[1], mb[0], 8'h96, sw_tab[m], 36, $sformatf("sweep%0d", m), s0, s1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
